spi_rx_fifo: RTL and testbench
==============================

# spi_rx_fifo

Byte FIFO placed directly downstream of `spi_master`. It absorbs each received word, presented as `out` qualified by a one-cycle `put`, and re-presents the words in order on a first-word-fall-through `get`/`empty` read port. That read port has the same protocol the SPI master uses on its own input. The FIFO decouples the SPI receive path from slower consumers, such as a UART transmitter or a second SPI master, and reports level and overflow status.

## Interface

Parameters:
- `W`, default 8: data word width in bits.
- `ORDER`, default 4: depth is 2^ORDER words (16 by default); ORDER ≥ 1.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in`  in  W  write data, sampled when `put` is high.
- `put`  in  1  write strobe, one word per cycle.
- `full`  out  1  FIFO holds 2^ORDER words; registered.
- `out`  out  W  head word; forced to 0 while `empty`.
- `get`  in  1  read strobe; consumes the head word on the clock edge.
- `empty`  out  1  FIFO holds 0 words; registered.
- `level`  out  ORDER+1  number of words stored; registered.
- `overflow`  out  1  sticky flag; set when a `put` is dropped.

## Operation

- Storage is a 2^ORDER × W array with write pointer `wp` and read pointer `rp`, each ORDER bits wide.
  - Both pointers wrap modulo 2^ORDER.
  - `level` is kept as a separate counter. It is not derived from the pointers.
- Write condition: `do_put = put & ~full`.
  - On the edge: `mem[wp] <= in`, then `wp <= wp + 1`.
- Read condition: `do_get = get & ~empty`.
  - On the edge: `rp <= rp + 1`.
- Count update: `level <= level + do_put - do_get`.
  - A simultaneous put and get leaves `level` unchanged.
- Flag updates, applied on the same edge from the next level value:
  - `empty <= (next level == 0)`.
  - `full <= (next level == 2^ORDER)`.
- `out = empty ? 0 : mem[rp]`, read combinationally from the array (first word falls through).
- Boundary cases:
  - `put` while `full` (even if `get` is also high that cycle): the word is dropped, `overflow <= 1`, no pointer or array change. The `get` still succeeds.
  - `get` while `empty` (even if `put` is also high): the `get` is ignored. The `put` is accepted, and the word appears on `out` after the edge.
  - Pointer wrap from 2^ORDER−1 to 0 is transparent. Order is preserved across wrap.
- `overflow` is cleared only by reset.
- Reset (`reset_n` low), asynchronous and effective immediately, including mid-burst:
  - `wp = rp = 0`, `level = 0`, `empty = 1`, `full = 0`, `overflow = 0`, `out = 0`.
  - Array contents are not cleared and are never visible, because `out` is masked while empty.
- Reset release is synchronous to `clock`. The first `put` is accepted on the first rising edge with `reset_n` high.

## Timing

- Write-to-read latency is 1 cycle. A word written on edge k:
  - is on `out` with `empty` = 0 right after edge k;
  - can be consumed by `get` at edge k+1.
- After a `get` at edge k, the next word (or 0 and `empty` = 1) is on `out` right after edge k.
- Throughput: one put and one get per cycle, sustained, at any level.
- `full`, `empty` and `level` change only on clock edges or reset. None has a combinational path from `put` or `get`.
- `out` has a combinational path from `rp`/`empty` only. There is no path from `get` to `out` within a cycle.
- Compatibility with the SPI master's single-cycle `put` pulse: it needs no handshake back. Drops are reported only through `overflow`.

## Test plan

1. Reset, then single word.
   - Hold `reset_n` low for 3 cycles: `empty`=1, `full`=0, `level`=0, `out`=0x00, `overflow`=0.
   - Release, then put 0xA5 for one cycle: next cycle `out`=0xA5, `empty`=0, `level`=1.
   - One `get`: `empty`=1, `out`=0x00.
2. Fill and drain with wrap.
   - Put 0x00…0x0F (16 words): `full`=1 after the 16th edge, `level`=16.
   - Get all 16: values come out 0x00…0x0F in order.
   - Repeat with 0x10…0x1F to exercise pointer wrap: order is preserved.
3. Overflow.
   - When full, put 0xEE: `overflow`=1, `level` stays 16.
   - Drain: 0xEE is never seen.
   - Put and get together while full: the get succeeds, the put is dropped, `level`=15.
4. Simultaneous on empty.
   - When empty, `put`=1 with 0x3C and `get`=1: after the edge `out`=0x3C and `level`=1 (get ignored).
5. Streaming.
   - With level 4, assert put and get every cycle for 40 cycles with data incrementing from 0x40.
   - `level` stays 4, `full` and `empty` stay 0, output sequence is exact.
   - Loopback check: connect the `spi_master` output to this FIFO with MOSI looped to MISO, send "Hello": reads return 0x48 0x65 0x6C 0x6C 0x6F.
6. Reset mid-operation.
   - At level 7, assert `reset_n` low between edges: outputs go to their reset values immediately, without a clock edge.
   - After release, put 0x99: the first read returns 0x99, with no stale data.

Source files
------------

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: byte FIFO that sits behind spi_master and re-presents received words
// on a first-word-fall-through read port.
//
// Ports:
//   clock, reset_n  rising-edge clock, asynchronous active-low reset
//   in, put         write data and one-cycle write strobe
//   full            registered, FIFO holds 2^ORDER words
//   out             head word, forced to 0 while empty (combinational from rp/empty)
//   get, empty      read strobe (consumes head on the edge), registered empty flag
//   level           registered word count, 0..2^ORDER
//   overflow        sticky, set when a put is dropped because the FIFO is full
module spi_rx_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned ORDER = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [W-1:0]     in,
  input  logic             put,
  output logic             full,
  output logic [W-1:0]     out,
  input  logic             get,
  output logic             empty,
  output logic [ORDER:0]   level,
  output logic             overflow
);

  localparam int unsigned Depth = 2 ** ORDER;

  logic [W-1:0]     mem_q [Depth];
  logic [ORDER-1:0] wp_q, wp_d;
  logic [ORDER-1:0] rp_q, rp_d;
  logic [ORDER:0]   level_q, level_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             overflow_q, overflow_d;
  logic             do_put, do_get;

  // Accept/consume decisions use only registered flags, so put/get never reach the
  // status outputs combinationally.
  always_comb begin
    do_put     = put & ~full_q;
    do_get     = get & ~empty_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    level_d    = level_q;
    overflow_d = overflow_q | (put & full_q);

    if (do_put) wp_d = wp_q + ORDER'(1);
    if (do_get) rp_d = rp_q + ORDER'(1);

    unique case ({do_put, do_get})
      2'b10:   level_d = level_q + (ORDER + 1)'(1);
      2'b01:   level_d = level_q - (ORDER + 1)'(1);
      default: level_d = level_q;
    endcase

    empty_d = (level_d == '0);
    // level only reaches 2^ORDER when the top bit is set.
    full_d  = level_d[ORDER];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; stale contents stay hidden because out is masked while empty.
  always_ff @(posedge clock) begin
    if (do_put) mem_q[wp_q] <= in;
  end

  assign out      = empty_q ? '0 : mem_q[rp_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_spi_rx_fifo.sv
module tb_spi_rx_fifo;

  logic       clock;
  logic       reset_n;
  logic [7:0] in;
  logic       put;
  logic       full;
  logic [7:0] out;
  logic       get;
  logic       empty;
  logic [4:0] level;
  logic       overflow;

  spi_rx_fifo #(.W(8), .ORDER(4)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in       (in),
    .put      (put),
    .full     (full),
    .out      (out),
    .get      (get),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Scoreboard: words pushed when an accepted put is driven, popped on accepted get.
  logic [7:0] sb[$];
  bit         m_ovf;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".level"}, int'(level), sb.size());
    chk({tag, ".empty"}, int'(empty), int'(sb.size() == 0));
    chk({tag, ".full"}, int'(full), int'(sb.size() == 16));
    chk({tag, ".overflow"}, int'(overflow), int'(m_ovf));
    chk({tag, ".out"}, int'(out), (sb.size() == 0) ? 0 : int'(sb[0]));
  endtask

  // One clock: drive at #1 after an edge, advance one edge, update model, check.
  task automatic cycle(input bit p, input logic [7:0] d, input bit g, input string tag);
    logic [7:0] pre_out;
    logic [7:0] exp_w;
    bit         was_full;
    bit         was_empty;
    put = p; in = d; get = g;
    pre_out   = out;
    was_full  = (sb.size() == 16);
    was_empty = (sb.size() == 0);
    @(posedge clock); #1;
    if (g && !was_empty) begin
      exp_w = sb.pop_front();
      chk({tag, ".pop"}, int'(pre_out), int'(exp_w));
    end
    if (p && !was_full) sb.push_back(d);
    if (p && was_full) m_ovf = 1'b1;
    put = 1'b0; get = 1'b0;
    check_state(tag);
  endtask

  typedef struct {
    bit         p;
    bit         g;
    logic [7:0] d;
    int         lvl;
    bit         emp;
    bit         ful;
    logic [7:0] o;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{p: 1, g: 0, d: 8'hA5, lvl: 1, emp: 0, ful: 0, o: 8'hA5};
    vecs[1] = '{p: 0, g: 1, d: 8'h00, lvl: 0, emp: 1, ful: 0, o: 8'h00};
    vecs[2] = '{p: 1, g: 1, d: 8'h3C, lvl: 1, emp: 0, ful: 0, o: 8'h3C};
    vecs[3] = '{p: 0, g: 1, d: 8'h00, lvl: 0, emp: 1, ful: 0, o: 8'h00};
    vecs[4] = '{p: 1, g: 0, d: 8'h11, lvl: 1, emp: 0, ful: 0, o: 8'h11};
    vecs[5] = '{p: 1, g: 0, d: 8'h22, lvl: 2, emp: 0, ful: 0, o: 8'h11};
    vecs[6] = '{p: 1, g: 1, d: 8'h33, lvl: 2, emp: 0, ful: 0, o: 8'h22};
    vecs[7] = '{p: 0, g: 1, d: 8'h00, lvl: 1, emp: 0, ful: 0, o: 8'h33};
    vecs[8] = '{p: 0, g: 1, d: 8'h00, lvl: 0, emp: 1, ful: 0, o: 8'h00};

    m_ovf   = 1'b0;
    reset_n = 1'b0;
    in      = '0;
    put     = 1'b0;
    get     = 1'b0;

    // Reset held for 3 cycles.
    repeat (3) @(posedge clock);
    #1;
    check_state("reset");
    chk("reset.out0", int'(out), 0);
    reset_n = 1'b1;

    // Table vectors: single word, get-on-empty with put, FWFT ordering.
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].p, vecs[i].d, vecs[i].g, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tlevel", i), int'(level), vecs[i].lvl);
      chk($sformatf("vec%0d.tempty", i), int'(empty), int'(vecs[i].emp));
      chk($sformatf("vec%0d.tfull", i), int'(full), int'(vecs[i].ful));
      chk($sformatf("vec%0d.tout", i), int'(out), int'(vecs[i].o));
    end

    // Fill and drain twice; second pass wraps both pointers.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) cycle(1'b1, 8'((pass * 16) + i), 1'b0, "fill");
      chk("fill.full16", int'(full), 1);
      chk("fill.level16", int'(level), 16);
      for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, "drain");
      chk("drain.empty", int'(empty), 1);
    end

    // Overflow: dropped put while full, then put+get while full.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, "ofill");
    cycle(1'b1, 8'hEE, 1'b0, "ovf");
    chk("ovf.flag", int'(overflow), 1);
    chk("ovf.level", int'(level), 16);
    cycle(1'b1, 8'hEE, 1'b1, "ovf_pg");
    chk("ovf_pg.level15", int'(level), 15);
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1, "odrain");
    chk("odrain.overflow_sticky", int'(overflow), 1);

    // Streaming at level 4 for 40 cycles.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, "spre");
    for (int i = 4; i < 44; i++) begin
      cycle(1'b1, 8'(8'h40 + i), 1'b1, "stream");
      chk("stream.level4", int'(level), 4);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, "spost");

    // "Hello" arriving as spaced single-cycle put pulses, then read back.
    begin
      logic [7:0] hello [5];
      hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
      for (int i = 0; i < 5; i++) begin
        cycle(1'b1, hello[i], 1'b0, "hello_put");
        repeat (3) cycle(1'b0, 8'h00, 1'b0, "hello_gap");
      end
      for (int i = 0; i < 5; i++) begin
        chk("hello.head", int'(out), int'(hello[i]));
        cycle(1'b0, 8'h00, 1'b1, "hello_get");
      end
    end

    // Asynchronous reset mid-operation at level 7.
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, "rfill");
    chk("rfill.level7", int'(level), 7);
    #2 reset_n = 1'b0;
    #1;
    sb.delete();
    m_ovf = 1'b0;
    check_state("async_rst");
    @(posedge clock); #3;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_state("post_rst");
    cycle(1'b1, 8'h99, 1'b0, "rst_put");
    chk("rst_put.out", int'(out), 8'h99);
    cycle(1'b0, 8'h00, 1'b1, "rst_get");
    chk("rst_get.empty", int'(empty), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
